// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single-port memory between the CPU (reads and writes) and the
//   display scanout engine (reads only). At most one transaction is
//   outstanding on the memory at a time. Reads keep the memory's
//   request/ack handshake: the request is held until ack, and the ack and
//   data go straight back to the requester that owns the read. CPU writes
//   are a single-cycle strobe to memory. Because a write can stall behind a
//   read, it returns a completion strobe (cpu_write_ack) in the cycle it is
//   performed.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN
//     defined   : when both requesters are pending in IDLE, the one that was
//                 not granted most recently wins, so grants alternate.
//     undefined : fixed priority, CPU over display. The display is served
//                 only when the CPU is not requesting.
//
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   cpu_read / cpu_read_idx      CPU read request (held until ack) + address
//   cpu_read_byte / cpu_read_ack read data mirror + one-cycle completion
//   cpu_write / _idx / _byte     CPU write request (held until ack)
//   cpu_write_ack                one-cycle strobe: write performed this cycle
//   disp_read / disp_read_idx    display read request + address
//   disp_read_byte/disp_read_ack read data mirror + one-cycle completion
//   mem_read / mem_read_idx      read request/address to memory
//   mem_read_byte / mem_read_ack read data/completion from memory (>=1 cycle)
//   mem_write / _idx / _byte     single-cycle write strobe to memory
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_read,
    input  logic [11:0] cpu_read_idx,
    output logic [7:0]  cpu_read_byte,
    output logic        cpu_read_ack,

    input  logic        cpu_write,
    input  logic [11:0] cpu_write_idx,
    input  logic [7:0]  cpu_write_byte,
    output logic        cpu_write_ack,

    input  logic        disp_read,
    input  logic [11:0] disp_read_idx,
    output logic [7:0]  disp_read_byte,
    output logic        disp_read_ack,

    output logic        mem_read,
    output logic [11:0] mem_read_idx,
    input  logic [7:0]  mem_read_byte,
    input  logic        mem_read_ack,

    output logic        mem_write,
    output logic [11:0] mem_write_idx,
    output logic [7:0]  mem_write_byte
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        DISP_RD = 2'd2
    } state_t;

    // Encoding of the priority pointer: who was granted most recently.
    localparam logic WHO_CPU  = 1'b0;
    localparam logic WHO_DISP = 1'b1;

    state_t state;
    state_t state_next;
    logic   last;
    logic   last_next;

    logic   cpu_req;
    logic   disp_req;
    logic   grant_cpu;
    logic   grant_disp;
    logic   grant_write;

    assign cpu_req  = cpu_read | cpu_write;
    assign disp_req = disp_read;

    // -------------------------------------------------------------------------
    // Arbitration. Grants are only issued from IDLE; a new transaction is
    // never started in a cycle where reset is being sampled, since that
    // cycle's state update is discarded anyway.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_cpu  = 1'b0;
        grant_disp = 1'b0;
        if (state == IDLE && !reset) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (cpu_req && disp_req) begin
                grant_cpu  = (last == WHO_DISP);
                grant_disp = (last == WHO_CPU);
            end else begin
                grant_cpu  = cpu_req;
                grant_disp = disp_req;
            end
`else
            grant_cpu  = cpu_req;
            grant_disp = disp_req & ~cpu_req;
`endif
        end
    end

    // A write wins over a simultaneous CPU read (protocol violation case):
    // the read simply stays pending for a later grant.
    assign grant_write = grant_cpu & cpu_write;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= WHO_DISP;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (grant_cpu) begin
                    last_next = WHO_CPU;
                    // Writes complete in the grant cycle, so only a read
                    // leaves IDLE.
                    if (!grant_write) begin
                        state_next = CPU_RD;
                    end
                end else if (grant_disp) begin
                    last_next  = WHO_DISP;
                    state_next = DISP_RD;
                end
            end
            CPU_RD, DISP_RD: begin
                if (mem_read_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic. Everything defaults to zero so that idx/byte outputs are
    // quiet whenever nothing is granted. A mem_read_ack seen in IDLE (stale
    // ack after reset) falls through to these defaults and is never routed.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_read       = 1'b0;
        mem_read_idx   = 12'd0;
        mem_write      = 1'b0;
        mem_write_idx  = 12'd0;
        mem_write_byte = 8'd0;
        cpu_read_byte  = 8'd0;
        cpu_read_ack   = 1'b0;
        cpu_write_ack  = 1'b0;
        disp_read_byte = 8'd0;
        disp_read_ack  = 1'b0;

        case (state)
            IDLE: begin
                if (grant_write) begin
                    mem_write      = 1'b1;
                    mem_write_idx  = cpu_write_idx;
                    mem_write_byte = cpu_write_byte;
                    cpu_write_ack  = 1'b1;
                end else if (grant_cpu) begin
                    mem_read     = 1'b1;
                    mem_read_idx = cpu_read_idx;
                end else if (grant_disp) begin
                    mem_read     = 1'b1;
                    mem_read_idx = disp_read_idx;
                end
            end
            CPU_RD: begin
                // Drop the request in the ack cycle to match the memory
                // handshake; read data is mirrored to both requesters and
                // only the owner's ack qualifies it.
                mem_read       = ~mem_read_ack;
                mem_read_idx   = cpu_read_idx;
                cpu_read_ack   = mem_read_ack;
                cpu_read_byte  = mem_read_byte;
                disp_read_byte = mem_read_byte;
            end
            DISP_RD: begin
                mem_read       = ~mem_read_ack;
                mem_read_idx   = disp_read_idx;
                disp_read_ack  = mem_read_ack;
                cpu_read_byte  = mem_read_byte;
                disp_read_byte = mem_read_byte;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter with a few directed scenarios followed by randomized
// CPU/display/memory traffic, and compares every output on every cycle
// against a transaction-level model (owner of the outstanding read, most
// recent grantee). Literal expectations in the directed part pin the model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_read;
    logic [11:0] cpu_read_idx;
    logic [7:0]  cpu_read_byte;
    logic        cpu_read_ack;
    logic        cpu_write;
    logic [11:0] cpu_write_idx;
    logic [7:0]  cpu_write_byte;
    logic        cpu_write_ack;
    logic        disp_read;
    logic [11:0] disp_read_idx;
    logic [7:0]  disp_read_byte;
    logic        disp_read_ack;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic        mem_read_ack;
    logic        mem_write;
    logic [11:0] mem_write_idx;
    logic [7:0]  mem_write_byte;

    mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_read       (cpu_read),
        .cpu_read_idx   (cpu_read_idx),
        .cpu_read_byte  (cpu_read_byte),
        .cpu_read_ack   (cpu_read_ack),
        .cpu_write      (cpu_write),
        .cpu_write_idx  (cpu_write_idx),
        .cpu_write_byte (cpu_write_byte),
        .cpu_write_ack  (cpu_write_ack),
        .disp_read      (disp_read),
        .disp_read_idx  (disp_read_idx),
        .disp_read_byte (disp_read_byte),
        .disp_read_ack  (disp_read_ack),
        .mem_read       (mem_read),
        .mem_read_idx   (mem_read_idx),
        .mem_read_byte  (mem_read_byte),
        .mem_read_ack   (mem_read_ack),
        .mem_write      (mem_write),
        .mem_write_idx  (mem_write_idx),
        .mem_write_byte (mem_write_byte)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam int NONE = 0;
    localparam int CPU  = 1;
    localparam int DISP = 2;

    // Model state: who owns the outstanding read, who was granted last.
    int m_owner;
    int m_last;

    int n_vec;
    int n_bad;

    // Snapshot of DUT outputs taken at the compare point of the last cycle.
    int s_mem_read, s_mem_read_idx, s_mem_write, s_mem_write_idx, s_mem_write_byte;
    int s_cpu_read_ack, s_cpu_read_byte, s_cpu_write_ack;
    int s_disp_read_ack, s_disp_read_byte;

    // Model results of the last cycle, used by the requesters to drop requests.
    bit g_cra, g_cwa, g_dra;

    task automatic cmp(input string name, input int act, input int exp);
        if (act != exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
            n_bad++;
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_vec++;
        cmp(name, act, exp);
    endtask

    // One clock cycle: inputs are already driven (called just after negedge).
    task automatic cycle();
        int winner;
        bit wr;
        int e_mr, e_mri, e_mw, e_mwi, e_mwb, e_rb, e_cra, e_cwa, e_dra;
        #1;
        winner = NONE;
        if (m_owner == NONE && !reset) begin
            if ((cpu_read || cpu_write) && disp_read)
                winner = (RR && m_last == CPU) ? DISP : CPU;
            else if (cpu_read || cpu_write)
                winner = CPU;
            else if (disp_read)
                winner = DISP;
        end
        wr = (winner == CPU) && cpu_write;

        e_mr = 0; e_mri = 0; e_mw = 0; e_mwi = 0; e_mwb = 0;
        e_rb = 0; e_cra = 0; e_cwa = 0; e_dra = 0;
        if (wr) begin
            e_mw = 1; e_mwi = int'(cpu_write_idx); e_mwb = int'(cpu_write_byte); e_cwa = 1;
        end else if (winner == CPU) begin
            e_mr = 1; e_mri = int'(cpu_read_idx);
        end else if (winner == DISP) begin
            e_mr = 1; e_mri = int'(disp_read_idx);
        end
        if (m_owner != NONE) begin
            e_mr  = mem_read_ack ? 0 : 1;
            e_mri = (m_owner == CPU) ? int'(cpu_read_idx) : int'(disp_read_idx);
            e_rb  = int'(mem_read_byte);
            e_cra = (m_owner == CPU  && mem_read_ack) ? 1 : 0;
            e_dra = (m_owner == DISP && mem_read_ack) ? 1 : 0;
        end

        s_mem_read       = int'(mem_read);
        s_mem_read_idx   = int'(mem_read_idx);
        s_mem_write      = int'(mem_write);
        s_mem_write_idx  = int'(mem_write_idx);
        s_mem_write_byte = int'(mem_write_byte);
        s_cpu_read_ack   = int'(cpu_read_ack);
        s_cpu_read_byte  = int'(cpu_read_byte);
        s_cpu_write_ack  = int'(cpu_write_ack);
        s_disp_read_ack  = int'(disp_read_ack);
        s_disp_read_byte = int'(disp_read_byte);

        n_vec++;
        cmp("mem_read",       s_mem_read,       e_mr);
        cmp("mem_read_idx",   s_mem_read_idx,   e_mri);
        cmp("mem_write",      s_mem_write,      e_mw);
        cmp("mem_write_idx",  s_mem_write_idx,  e_mwi);
        cmp("mem_write_byte", s_mem_write_byte, e_mwb);
        cmp("cpu_read_ack",   s_cpu_read_ack,   e_cra);
        cmp("cpu_read_byte",  s_cpu_read_byte,  e_rb);
        cmp("cpu_write_ack",  s_cpu_write_ack,  e_cwa);
        cmp("disp_read_ack",  s_disp_read_ack,  e_dra);
        cmp("disp_read_byte", s_disp_read_byte, e_rb);

        g_cra = (e_cra != 0);
        g_cwa = (e_cwa != 0);
        g_dra = (e_dra != 0);

        if (reset) begin
            m_owner = NONE;
            m_last  = DISP;
        end else if (m_owner != NONE) begin
            if (mem_read_ack) m_owner = NONE;
        end else if (winner != NONE) begin
            m_last = winner;
            if (!wr) m_owner = winner;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; disp_read = 1'b0;
        cpu_read_idx = 12'd0; cpu_write_idx = 12'd0; cpu_write_byte = 8'd0;
        disp_read_idx = 12'd0; mem_read_ack = 1'b0; mem_read_byte = 8'd0;
    endtask

    initial begin
        bit cr_p, cw_p, dr_p;
        logic [11:0] cr_i, cw_i, dr_i;
        logic [7:0] cw_b;
        int rem, prev_owner, exp_idx;

        n_vec = 0; n_bad = 0;
        quiet();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_owner = NONE; m_last = DISP;

        // Reset held with stray requests present: nothing may be granted.
        cpu_write = 1'b1; cpu_write_idx = 12'h333; cpu_write_byte = 8'h11;
        cycle();
        lit("reset_no_write", s_mem_write, 0);
        lit("reset_no_wack", s_cpu_write_ack, 0);
        quiet();
        cycle();
        lit("idle_mem_read", s_mem_read, 0);
        lit("idle_mem_write_idx", s_mem_write_idx, 0);

        // Single CPU read of 0x020, mem returns 0xAB after 1 cycle.
        cpu_read = 1'b1; cpu_read_idx = 12'h020;
        cycle();
        lit("rd_grant", s_mem_read, 1);
        lit("rd_grant_idx", s_mem_read_idx, 12'h020);
        mem_read_ack = 1'b1; mem_read_byte = 8'hAB;
        cycle();
        lit("rd_cpu_ack", s_cpu_read_ack, 1);
        lit("rd_cpu_byte", s_cpu_read_byte, 8'hAB);
        lit("rd_disp_ack", s_disp_read_ack, 0);
        quiet();
        cycle();

        // CPU write of 0x5A to 0x12F while IDLE.
        cpu_write = 1'b1; cpu_write_idx = 12'h12F; cpu_write_byte = 8'h5A;
        cycle();
        lit("wr_strobe", s_mem_write, 1);
        lit("wr_idx", s_mem_write_idx, 12'h12F);
        lit("wr_byte", s_mem_write_byte, 8'h5A);
        lit("wr_ack", s_cpu_write_ack, 1);
        quiet();
        cycle();

        // Display read of 0x100 with 3-cycle latency; CPU write raised in cycle 1.
        disp_read = 1'b1; disp_read_idx = 12'h100;
        cycle();
        lit("dst_grant_idx", s_mem_read_idx, 12'h100);
        cpu_write = 1'b1; cpu_write_idx = 12'h130; cpu_write_byte = 8'h77;
        cycle();
        lit("dst_wack_c1", s_cpu_write_ack, 0);
        cycle();
        lit("dst_wack_c2", s_cpu_write_ack, 0);
        mem_read_ack = 1'b1; mem_read_byte = 8'h3C;
        cycle();
        lit("dst_disp_ack_c3", s_disp_read_ack, 1);
        lit("dst_wack_c3", s_cpu_write_ack, 0);
        disp_read = 1'b0; mem_read_ack = 1'b0;
        cycle();
        lit("dst_wack_c4", s_cpu_write_ack, 1);
        lit("dst_write_c4", s_mem_write, 1);
        quiet();
        cycle();

        // Reset during CPU_RD, ack arrives the cycle after reset.
        cpu_read = 1'b1; cpu_read_idx = 12'h040;
        cycle();
        lit("rmid_grant", s_mem_read, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0; cpu_read = 1'b0;
        mem_read_ack = 1'b1; mem_read_byte = 8'hEE;
        disp_read = 1'b1; disp_read_idx = 12'h1A0;
        cycle();
        lit("rmid_no_cpu_ack", s_cpu_read_ack, 0);
        lit("rmid_no_disp_ack", s_disp_read_ack, 0);
        lit("rmid_disp_grant", s_mem_read, 1);
        lit("rmid_disp_idx", s_mem_read_idx, 12'h1A0);
        mem_read_byte = 8'h42;
        cycle();
        lit("rmid_disp_ack", s_disp_read_ack, 1);
        lit("rmid_disp_byte", s_disp_read_byte, 8'h42);
        quiet();
        cycle();

        // Both requesters reading continuously, starting from reset.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cpu_read = 1'b1; cpu_read_idx = 12'h010;
        disp_read = 1'b1; disp_read_idx = 12'h150;
        mem_read_byte = 8'h99;
        for (int t = 0; t < 6; t++) begin
            mem_read_ack = 1'b0;
            cycle();
            exp_idx = (RR && (t % 2 == 1)) ? 12'h150 : 12'h010;
            lit("alt_grant_idx", s_mem_read_idx, exp_idx);
            mem_read_ack = 1'b1;
            cycle();
            lit("alt_cpu_ack", s_cpu_read_ack, (exp_idx == 12'h010) ? 1 : 0);
            lit("alt_disp_ack", s_disp_read_ack, (exp_idx == 12'h150) ? 1 : 0);
        end
        quiet();
        reset = 1'b1;
        cycle();

        // Randomized traffic against the model.
        cr_p = 1'b0; cw_p = 1'b0; dr_p = 1'b0;
        cr_i = 12'd0; cw_i = 12'd0; dr_i = 12'd0; cw_b = 8'd0; rem = 0;
        for (int k = 0; k < 4000; k++) begin
            reset          = ($urandom_range(0, 199) == 0);
            cpu_read       = cr_p;
            cpu_read_idx   = cr_p ? cr_i : 12'($urandom);
            cpu_write      = cw_p;
            cpu_write_idx  = cw_p ? cw_i : 12'($urandom);
            cpu_write_byte = cw_p ? cw_b : 8'($urandom);
            disp_read      = dr_p;
            disp_read_idx  = dr_p ? dr_i : 12'($urandom);
            mem_read_byte  = 8'($urandom);
            if (m_owner != NONE) mem_read_ack = (rem == 0);
            else                 mem_read_ack = ($urandom_range(0, 7) == 0);
            prev_owner = m_owner;
            cycle();
            if (prev_owner == NONE && m_owner != NONE) rem = $urandom_range(0, 3);
            else if (m_owner != NONE && rem > 0)      rem--;

            if (g_cra) cr_p = 1'b0;
            if (g_cwa) cw_p = 1'b0;
            if (g_dra) dr_p = 1'b0;
            if (!cr_p && $urandom_range(0, 3) == 0) begin
                cr_p = 1'b1; cr_i = 12'($urandom);
            end
            if (!cw_p && (!cr_p || $urandom_range(0, 15) == 0) && $urandom_range(0, 3) == 0) begin
                cw_p = 1'b1; cw_i = 12'($urandom); cw_b = 8'($urandom);
            end
            if (!dr_p && $urandom_range(0, 2) == 0) begin
                dr_p = 1'b1; dr_i = 12'h100 | 12'($urandom_range(0, 255));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port `mem` block between two requesters: the CPU, which issues reads and writes, and the display scanout engine, which only reads the 0x100..0x1FF screen region. The block sits between `cpu` and `mem`.

- Only one transaction is outstanding on the memory at a time.
- Each requester keeps the existing `mem` handshake. A read is held high until ack and is dropped in the ack cycle.
- CPU writes gain a completion strobe, because a write can now stall.

## Interface
Parameters:
- none (arbitration policy is selected by macro, see Configuration)

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `cpu_read`  in  1  CPU read request, held until `cpu_read_ack`
- `cpu_read_idx`  in  12  CPU read address
- `cpu_read_byte`  out  8  read data, valid when `cpu_read_ack`
- `cpu_read_ack`  out  1  one-cycle read completion to CPU
- `cpu_write`  in  1  CPU write request, held until `cpu_write_ack`
- `cpu_write_idx`  in  12  CPU write address
- `cpu_write_byte`  in  8  CPU write data
- `cpu_write_ack`  out  1  one-cycle strobe: write performed this cycle
- `disp_read`  in  1  display read request, held until `disp_read_ack`
- `disp_read_idx`  in  12  display read address
- `disp_read_byte`  out  8  read data, valid when `disp_read_ack`
- `disp_read_ack`  out  1  one-cycle read completion to display
- `mem_read`  out  1  read request to `mem`
- `mem_read_idx`  out  12  read address to `mem`
- `mem_read_byte`  in  8  data from `mem`, valid with `mem_read_ack`
- `mem_read_ack`  in  1  `mem` read completion; latency 1 cycle or more
- `mem_write`  out  1  single-cycle write strobe to `mem`
- `mem_write_idx`  out  12  write address to `mem`
- `mem_write_byte`  out  8  write data to `mem`

## Operation
State register values:
- IDLE
- CPU_RD (CPU read outstanding)
- DISP_RD (display read outstanding)

Priority pointer `last`:
- 1 bit recording which requester was granted most recently.
- Reset value is `last`=DISP, so the CPU wins the first tie.

Behaviour in IDLE:
- The candidates are the CPU (`cpu_read|cpu_write`) and the display (`disp_read`). Arbitration follows the Configuration policy.
- CPU granted with `cpu_write`:
  - `mem_write`=1 and idx/byte are passed through combinationally.
  - `cpu_write_ack`=1 in the same cycle.
  - State stays IDLE and `last`<=CPU.
  - If `cpu_read` and `cpu_write` are both high (a protocol violation), the write is served and the read stays pending.
- CPU granted with a read:
  - `mem_read`=1 with `mem_read_idx`=`cpu_read_idx` in the same cycle.
  - Next state is CPU_RD and `last`<=CPU.
- Display granted: same as the CPU read case, using `disp_read_idx`. Next state is DISP_RD and `last`<=DISP.

Behaviour in CPU_RD / DISP_RD:
- `mem_read`=!`mem_read_ack` and `mem_read_idx` is the owner's idx.
- On `mem_read_ack`:
  - Only the owner's `*_read_ack` is raised.
  - Both `*_read_byte` outputs mirror `mem_read_byte` at all times.
  - Next state is IDLE.
- While a read is outstanding, all other requests wait, including CPU writes (`cpu_write_ack`=0).

Other rules:
- `mem_read_ack` received in IDLE (a stale ack after reset) is ignored and never routed to a requester.
- Outputs are all 0 whenever nothing is granted, including all idx/byte outputs.

## Timing
- Reset values:
  - State IDLE, `last`=DISP.
  - All request, ack and strobe outputs are 0; idx/byte outputs are 0.
- Grant latency: 0 cycles from request to memory when the request arrives in IDLE and wins.
- Read latency to requester: equal to `mem` latency, with no added cycles.
- Back-to-back spacing: the next transaction is granted in the cycle after `mem_read_ack`, because state returns to IDLE then. There is therefore one IDLE cycle between two reads.
- Writes: one cycle each. Consecutive CPU writes can complete on consecutive cycles if the display does not win.
- Reset mid-read:
  - State goes to IDLE and `mem_read` drops in the cycle after reset is sampled.
  - The in-flight ack is then dropped, as described under Operation.
  - Requesters must re-issue.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both requesters are pending in IDLE, the requester not equal to `last` is granted. This gives alternation and bounds the wait to one transaction.
- Undefined: fixed priority, CPU over display. The display is served only when the CPU is idle. `last` is still maintained but does not affect the decision.

## Test plan
- Single CPU read of 0x020, mem returns 0xAB after 1 cycle:
  - `mem_read`=1 in cycle 0.
  - `cpu_read_ack`=1 and `cpu_read_byte`=0xAB in cycle 1.
  - `disp_read_ack` stays 0.
- CPU write of 0x5A to 0x12F while IDLE: `mem_write`=1 with idx 0x12F and byte 0x5A, and `cpu_write_ack`=1, all in the same cycle.
- Display reading 0x100 with 3-cycle mem latency, CPU write raised in cycle 1:
  - The write stalls, with `cpu_write_ack`=0, through the ack cycle 3.
  - The write is performed in cycle 4.
- Both requesters continuously reading:
  - With the macro, grants alternate CPU, DISP, CPU, ...
  - Without the macro, the CPU is granted every time and `disp_read_ack` never fires.
- Reset asserted during CPU_RD before the ack, then the ack arrives the cycle after reset:
  - No `cpu_read_ack` is issued.
  - State is IDLE, and the next display request is granted normally.
